// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and forwarding selects.
package pipeline_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // Forwarding source for one EX operand; MEM beats WB, r0 is never forwarded.
   // A load in MEM has no data yet, so it cannot feed EX from the EX/MEM buffer.
   function automatic fwd_sel_e fwd_select(
      input logic [4:0] src_num,
      input logic [4:0] rd_mem,
      input logic       we_mem,
      input logic       load_mem,
      input logic [4:0] rd_wb,
      input logic       we_wb
   );
      if (we_mem && !load_mem && (rd_mem != 5'd0) && (rd_mem == src_num)) begin
         return FWD_MEM;
      end else if (we_wb && (rd_wb != 5'd0) && (rd_wb == src_num)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: step only when requested and not yet saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: buffer stall/flush controls, PC enable, EX forwarding
// selects, memory-wait FSM with timeout, and stall/flush performance counters.
module hazard_ctrl_unit #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [4:0]       rs_num_ID,
   input  logic [4:0]       rt_num_ID,
   input  logic             uses_rs_ID,
   input  logic             uses_rt_ID,
   input  logic [4:0]       rs_num_EX,
   input  logic [4:0]       rt_num_EX,
   input  logic [4:0]       rd_num_EX,
   input  logic             reg_write_enable_EX,
   input  logic             mem_or_reg_EX,
   input  logic [4:0]       rd_num_MEM,
   input  logic             reg_write_enable_MEM,
   input  logic             mem_or_reg_MEM,
   input  logic [4:0]       rd_num_WB,
   input  logic             reg_write_enable_WB,
   input  logic             take_branch_MEM,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             stall_IF_ID,
   output logic             flush_IF_ID,
   output logic             stall_ID_EX,
   output logic             flush_ID_EX,
   output logic             stall_EX_MEM,
   output logic             flush_EX_MEM,
   output logic             stall_MEM_WB,
   output logic             flush_MEM_WB,
   output logic [1:0]       fwd_rs_sel,
   output logic [1:0]       fwd_rt_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   import pipeline_pkg::*;

   localparam int unsigned           WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   hz_state_e          state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
   logic               mem_timeout_q, mem_timeout_d;
   logic               wait_now;
   logic               load_use;
   logic               stall_inc;
   logic               flush_inc;

   assign wait_inc = wait_q + WAIT_W'(1);

   // Hazard detection. The cycle that returns mem_ready is not a wait cycle.
   always_comb begin
      if (state_q == MEM_WAIT) begin
         wait_now = ~mem_ready;
      end else begin
         wait_now = mem_req_MEM & ~mem_ready;
      end
      load_use = mem_or_reg_EX & reg_write_enable_EX & (rd_num_EX != 5'd0) &
                 ((uses_rs_ID & (rs_num_ID == rd_num_EX)) |
                  (uses_rt_ID & (rt_num_ID == rd_num_EX)));
   end

   // Buffer controls and PC enable, prioritised wait > branch > load-use; all 0 in reset.
   always_comb begin
      pc_we        = 1'b0;
      stall_IF_ID  = 1'b0;
      flush_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      flush_ID_EX  = 1'b0;
      stall_EX_MEM = 1'b0;
      flush_EX_MEM = 1'b0;
      stall_MEM_WB = 1'b0;
      flush_MEM_WB = 1'b0;
      if (rst_b) begin
         if (wait_now) begin
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
         end else if (take_branch_MEM) begin
            pc_we        = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
         end else if (load_use) begin
            stall_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
         end else begin
            pc_we        = 1'b1;
         end
      end
   end

   // EX operand forwarding selects.
   always_comb begin
      fwd_rs_sel = FWD_RF;
      fwd_rt_sel = FWD_RF;
      if (rst_b) begin
         fwd_rs_sel = fwd_select(rs_num_EX, rd_num_MEM, reg_write_enable_MEM, mem_or_reg_MEM,
                                 rd_num_WB, reg_write_enable_WB);
         fwd_rt_sel = fwd_select(rt_num_EX, rd_num_MEM, reg_write_enable_MEM, mem_or_reg_MEM,
                                 rd_num_WB, reg_write_enable_WB);
      end
   end

   // Memory-wait FSM next state, wait counter and sticky timeout flag.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         RUN: begin
            if (mem_req_MEM && !mem_ready) begin
               state_d = MEM_WAIT;
               wait_d  = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_inc == WAIT_LIMIT) begin
               state_d       = RUN;
               wait_d        = '0;
               mem_timeout_d = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= RUN;
         wait_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

   assign stall_inc = ~pc_we;
   assign flush_inc = flush_IF_ID | flush_ID_EX | flush_EX_MEM | flush_MEM_WB;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(
      .W(CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule
